mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Memory and writeback stage of the pipelined core. Takes the EXE/MEM pipeline register outputs, performs load/store through a word-wide SRAM request/acknowledge port, and produces `Result_WB`/`Dest_WB`/`WriteBackEn` for the register file, which writes on the falling edge. While a memory access is outstanding it asserts `freeze` to stall every upstream stage.

## Interface
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `SRAM_AW`, default 16: SRAM word-address width.

- `clk` in 1: clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `alu_result` in 32: EXE result, used as the byte address for memory ops and as the writeback value otherwise.
- `val_rm` in 32: store data.
- `dest` in 4: destination register.
- `wb_en` in 1: instruction writes a register.
- `mem_r_en` in 1: load.
- `mem_w_en` in 1: store.
- `sram_req` out 1: access request.
- `sram_we` out 1: 1 = write, 0 = read.
- `sram_addr` out SRAM_AW: word address.
- `sram_wdata` out 32: write data.
- `sram_ack` in 1: access complete; `sram_rdata` is valid in the same cycle.
- `sram_rdata` in 32: read data.
- `freeze` out 1: stall upstream stages.
- `Result_WB` out 32: writeback value.
- `Dest_WB` out 4: writeback register.
- `WriteBackEn` out 1: writeback enable.

## Operation
- `mem_op = mem_r_en | mem_w_en`. If both are set, the op is a store: `sram_we = 1`, and writeback selects the ALU value.
- Address: `sram_addr = ((alu_result - BASE_ADDR) >> 2)`, truncated to SRAM_AW bits. Subtraction is modulo 2^32. The low 2 bits are ignored and there is no range check.
- `sram_wdata = val_rm`. `sram_we = mem_w_en`.
- FSM states:
  - IDLE: if `mem_op`, go to ACCESS.
  - ACCESS: `sram_req = 1`; on `sram_ack`, capture `sram_rdata` into `rd_q` and go to DONE.
  - DONE: go to IDLE unconditionally.
- `freeze = mem_op & (state != DONE)` (combinational). Non-memory instructions never freeze.
- `sram_ack` is ignored outside ACCESS.
- WB register, updated every rising edge:
  - If `freeze`, load a bubble: `wb_en_q = 0`, other fields hold.
  - Otherwise load `wb_en`, `dest`, `mem_r_en & ~mem_w_en`, `alu_result`, and read data. Read data is `rd_q`, or `sram_rdata` if the ack arrives in DONE bypass (not applicable, since DONE always follows the ack).
- Output mapping: `Result_WB = sel_mem_q ? rd_q_wb : alu_q`, `Dest_WB = dest_q`, `WriteBackEn = wb_en_q`.

## Timing
- Reset: state IDLE. `sram_req = 0`. `rd_q`, `alu_q` = 0. `dest_q = 0`. `wb_en_q`, `sel_mem_q` = 0. Hence `WriteBackEn = 0`, `Result_WB = 0`, `Dest_WB = 0`. `freeze` follows its combinational definition.
- Non-memory instruction: the value is visible on the WB outputs 1 cycle after it is presented and is written at the following falling edge.
- Memory op presented in cycle 0 (IDLE, `freeze = 1`):
  - cycle 1: ACCESS, `sram_req = 1`.
  - With ack in cycle 1+k (k ≥ 0): DONE in cycle 2+k with `freeze = 0`.
  - The WB register captures at the end of cycle 2+k; outputs are valid in cycle 3+k.
  - Minimum freeze: 2 cycles.
- `sram_addr`, `sram_we` and `sram_wdata` are stable for the whole ACCESS period, because inputs are held by `freeze`.
- Reset in ACCESS: `sram_req` drops immediately, the state returns to IDLE, and the pending access is abandoned.
- Back-to-back memory ops: after DONE, a new access starts from IDLE with no idle gap required by the upstream pipeline.

## Structure
- Package `mem_wb_pkg`: state enum (IDLE, ACCESS, DONE) and the default `BASE_ADDR` constant.
- Sub-module `mem_wb_reg`: the WB pipeline register with freeze-as-bubble, async reset, and output mux. The FSM and SRAM interface remain in the top module.

## Test plan
- ALU op `alu_result = 0x1234`, `dest = 3`, `wb_en = 1` → next cycle `Result_WB = 0x1234`, `Dest_WB = 3`, `WriteBackEn = 1`; `freeze` never high.
- Store `alu_result = 1032`, `val_rm = 0xCAFEBABE`, ack after 3 cycles of req → `sram_addr = 2`, `sram_we = 1`, `sram_wdata = 0xCAFEBABE`; `freeze` high exactly 5 cycles; `WriteBackEn = 0` throughout.
- Load `alu_result = 1024`, `dest = 5`, `rdata = 0xDEADBEEF` with ack in the first ACCESS cycle → freeze high 2 cycles; then `Result_WB = 0xDEADBEEF`, `Dest_WB = 5`, `WriteBackEn = 1` for exactly one cycle.
- Spurious `sram_ack` pulses while IDLE or during ALU ops → no state change, no writeback corruption.
- `rst` asserted in ACCESS → `sram_req = 0` and `WriteBackEn = 0` immediately; after release, a new load completes normally.
- `alu_result = 0` (below base) load → `sram_addr = 0xFF00` (`SRAM_AW = 16`) wraps without error.

Source files
------------

// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared types and constants for the memory/writeback stage.
package mem_wb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  localparam logic [31:0] DEF_BASE_ADDR = 32'd1024;
endpackage

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: WB pipeline register; a frozen cycle loads a bubble, other fields hold.
module mem_wb_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en,
  input  logic [3:0]  dest,
  input  logic        sel_mem,
  input  logic [31:0] alu,
  input  logic [31:0] rd,
  output logic [31:0] Result_WB,
  output logic [3:0]  Dest_WB,
  output logic        WriteBackEn
);
  logic        wb_en_q, wb_en_d, sel_mem_q, sel_mem_d;
  logic [3:0]  dest_q, dest_d;
  logic [31:0] alu_q, alu_d, rd_q_wb, rd_d_wb;
  always_comb begin
    wb_en_d   = freeze ? 1'b0 : wb_en;
    dest_d    = freeze ? dest_q : dest;
    sel_mem_d = freeze ? sel_mem_q : sel_mem;
    alu_d     = freeze ? alu_q : alu;
    rd_d_wb   = freeze ? rd_q_wb : rd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en_q   <= 1'b0;
      dest_q    <= '0;
      sel_mem_q <= 1'b0;
      alu_q     <= '0;
      rd_q_wb   <= '0;
    end else begin
      wb_en_q   <= wb_en_d;
      dest_q    <= dest_d;
      sel_mem_q <= sel_mem_d;
      alu_q     <= alu_d;
      rd_q_wb   <= rd_d_wb;
    end
  end
  assign Result_WB   = sel_mem_q ? rd_q_wb : alu_q;
  assign Dest_WB     = dest_q;
  assign WriteBackEn = wb_en_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: load/store through a req/ack SRAM port, stalling upstream while an access is pending.
module mem_wb_stage import mem_wb_pkg::*; #(
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          SRAM_AW   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        val_rm,
  input  logic [3:0]         dest,
  input  logic               wb_en,
  input  logic               mem_r_en,
  input  logic               mem_w_en,
  output logic               sram_req,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic               sram_ack,
  input  logic [31:0]        sram_rdata,
  output logic               freeze,
  output logic [31:0]        Result_WB,
  output logic [3:0]         Dest_WB,
  output logic               WriteBackEn
);
  state_e      state_q, state_d;
  logic [31:0] rd_q, rd_d;
  logic        mem_op;
  assign mem_op     = mem_r_en | mem_w_en;
  assign sram_we    = mem_w_en;
  assign sram_wdata = val_rm;
  assign sram_addr  = SRAM_AW'((alu_result - BASE_ADDR) >> 2);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE)   ? (mem_op ? ACCESS : IDLE) :
              (state_q == ACCESS) ? (sram_ack ? DONE : ACCESS) : IDLE;
    rd_d    = (state_q == ACCESS && sram_ack) ? sram_rdata : rd_q;
  end
  always_comb begin
    sram_req = (state_q == ACCESS);
    freeze   = mem_op & (state_q != DONE);
  end
  mem_wb_reg u_wb (
    .clk         (clk),
    .rst         (rst),
    .freeze      (freeze),
    .wb_en       (wb_en),
    .dest        (dest),
    .sel_mem     (mem_r_en & ~mem_w_en),
    .alu         (alu_result),
    .rd          (rd_q),
    .Result_WB   (Result_WB),
    .Dest_WB     (Dest_WB),
    .WriteBackEn (WriteBackEn)
  );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed scenarios for the memory/writeback stage.
module tb_mem_wb_stage;
  logic        clk = 0, rst = 1;
  logic [31:0] alu_result = 0, val_rm = 0, sram_rdata = 0, sram_wdata, Result_WB;
  logic [3:0]  dest = 0, Dest_WB;
  logic        wb_en = 0, mem_r_en = 0, mem_w_en = 0, sram_ack = 0;
  logic        sram_req, sram_we, freeze, WriteBackEn;
  logic [15:0] sram_addr;
  int total = 0, bad = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .alu_result(alu_result), .val_rm(val_rm), .dest(dest),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_req(sram_req),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_ack(sram_ack),
    .sram_rdata(sram_rdata), .freeze(freeze), .Result_WB(Result_WB), .Dest_WB(Dest_WB),
    .WriteBackEn(WriteBackEn)
  );

  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic set_op(input logic [31:0] a, input logic [3:0] d, input logic w, input logic r, input logic s);
    alu_result = a; dest = d; wb_en = w; mem_r_en = r; mem_w_en = s;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (WriteBackEn !== 1'b0) begin bad++; $display("FAIL reset_wbe got=%b exp=0", WriteBackEn); end
    total++; if (Result_WB !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", Result_WB); end
    total++; if (Dest_WB !== 4'h0) begin bad++; $display("FAIL reset_dest got=%h exp=0", Dest_WB); end
    total++; if (sram_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", sram_req); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL reset_freeze got=%b exp=0", freeze); end
    rst = 0;
  endtask

  task automatic test_alu();
    next(); set_op(32'h1234, 4'd3, 1, 0, 0);
    @(negedge clk);
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL alu_freeze got=%b exp=0", freeze); end
    next(); set_op(32'h0, 4'd0, 0, 0, 0);
    @(negedge clk);
    total++; if (Result_WB !== 32'h1234) begin bad++; $display("FAIL alu_result got=%h exp=1234", Result_WB); end
    total++; if (Dest_WB !== 4'd3) begin bad++; $display("FAIL alu_dest got=%h exp=3", Dest_WB); end
    total++; if (WriteBackEn !== 1'b1) begin bad++; $display("FAIL alu_wbe got=%b exp=1", WriteBackEn); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL alu_freeze2 got=%b exp=0", freeze); end
  endtask

  task automatic test_store();
    int fc = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin next(); set_op(32'd1032, 4'd7, 0, 0, 1); val_rm = 32'hCAFEBABE; end
      else next();
      sram_ack = (c == 4);
      @(negedge clk);
      if (freeze) fc++;
      total++; if (WriteBackEn !== 1'b0) begin bad++; $display("FAIL st_wbe c=%0d got=%b exp=0", c, WriteBackEn); end
      total++; if (sram_req !== (c >= 1 && c <= 4)) begin bad++; $display("FAIL st_req c=%0d got=%b", c, sram_req); end
      if (c >= 1 && c <= 4) begin
        total++;
        if (sram_addr !== 16'd2 || sram_we !== 1'b1 || sram_wdata !== 32'hCAFEBABE) begin
          bad++; $display("FAIL st_port c=%0d addr=%h we=%b wdata=%h exp 0002/1/cafebabe", c, sram_addr, sram_we, sram_wdata);
        end
      end
    end
    next(); set_op(0, 0, 0, 0, 0); sram_ack = 0;
    @(negedge clk);
    total++; if (fc !== 5) begin bad++; $display("FAIL st_freeze_cycles got=%0d exp=5", fc); end
    total++; if (WriteBackEn !== 1'b0) begin bad++; $display("FAIL st_wbe_after got=%b exp=0", WriteBackEn); end
  endtask

  task automatic test_load();
    int fc = 0;
    next(); set_op(32'd1024, 4'd5, 1, 1, 0); sram_rdata = 32'hDEADBEEF;
    @(negedge clk); if (freeze) fc++;
    next(); sram_ack = 1;
    @(negedge clk); if (freeze) fc++;
    total++; if (sram_req !== 1'b1 || sram_addr !== 16'd0 || sram_we !== 1'b0) begin
      bad++; $display("FAIL ld_port req=%b addr=%h we=%b exp 1/0000/0", sram_req, sram_addr, sram_we); end
    next(); sram_ack = 0; sram_rdata = 32'h0;
    @(negedge clk); if (freeze) fc++;
    total++; if (fc !== 2) begin bad++; $display("FAIL ld_freeze_cycles got=%0d exp=2", fc); end
    next(); set_op(0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (Result_WB !== 32'hDEADBEEF) begin bad++; $display("FAIL ld_result got=%h exp=deadbeef", Result_WB); end
    total++; if (Dest_WB !== 4'd5) begin bad++; $display("FAIL ld_dest got=%h exp=5", Dest_WB); end
    total++; if (WriteBackEn !== 1'b1) begin bad++; $display("FAIL ld_wbe got=%b exp=1", WriteBackEn); end
    next();
    @(negedge clk);
    total++; if (WriteBackEn !== 1'b0) begin bad++; $display("FAIL ld_wbe_once got=%b exp=0", WriteBackEn); end
  endtask

  task automatic test_spurious();
    next(); set_op(32'h55, 4'd2, 1, 0, 0); sram_ack = 1; sram_rdata = 32'h999;
    @(negedge clk);
    total++; if (freeze !== 1'b0 || sram_req !== 1'b0) begin bad++; $display("FAIL sp_idle freeze=%b req=%b exp 0/0", freeze, sram_req); end
    next();
    @(negedge clk);
    total++; if (Result_WB !== 32'h55 || Dest_WB !== 4'd2 || WriteBackEn !== 1'b1) begin
      bad++; $display("FAIL sp_wb result=%h dest=%h wbe=%b exp 55/2/1", Result_WB, Dest_WB, WriteBackEn); end
    total++; if (sram_req !== 1'b0) begin bad++; $display("FAIL sp_req got=%b exp=0", sram_req); end
    next(); sram_ack = 0; set_op(0, 0, 0, 0, 0);
  endtask

  task automatic test_rst_access();
    next(); set_op(32'd1028, 4'd9, 1, 1, 0);
    next();
    @(negedge clk);
    total++; if (sram_req !== 1'b1) begin bad++; $display("FAIL ra_req_pre got=%b exp=1", sram_req); end
    rst = 1; #1;
    total++; if (sram_req !== 1'b0) begin bad++; $display("FAIL ra_req_drop got=%b exp=0", sram_req); end
    total++; if (WriteBackEn !== 1'b0 || Result_WB !== 32'h0) begin
      bad++; $display("FAIL ra_wb wbe=%b result=%h exp 0/0", WriteBackEn, Result_WB); end
    @(negedge clk); rst = 0;
    next(); sram_ack = 1; sram_rdata = 32'h0BADF00D;
    @(negedge clk);
    total++; if (sram_req !== 1'b1 || sram_addr !== 16'd1) begin bad++; $display("FAIL ra_restart req=%b addr=%h exp 1/0001", sram_req, sram_addr); end
    next(); sram_ack = 0;
    @(negedge clk);
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL ra_done_freeze got=%b exp=0", freeze); end
    next(); set_op(0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (Result_WB !== 32'h0BADF00D || Dest_WB !== 4'd9 || WriteBackEn !== 1'b1) begin
      bad++; $display("FAIL ra_wb_after result=%h dest=%h wbe=%b exp 0badf00d/9/1", Result_WB, Dest_WB, WriteBackEn); end
  endtask

  task automatic test_wrap();
    next(); set_op(32'h0, 4'd4, 1, 1, 0);
    next(); sram_ack = 1; sram_rdata = 32'h1111;
    @(negedge clk);
    total++; if (sram_addr !== 16'hFF00) begin bad++; $display("FAIL wrap_addr got=%h exp=ff00", sram_addr); end
    next(); sram_ack = 0;
    next(); set_op(0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (Result_WB !== 32'h1111 || Dest_WB !== 4'd4) begin bad++; $display("FAIL wrap_wb result=%h dest=%h exp 1111/4", Result_WB, Dest_WB); end
  endtask

  task automatic test_back_to_back();
    next(); set_op(32'd1040, 4'd1, 1, 1, 0);
    next(); sram_ack = 1; sram_rdata = 32'hAAAA0001;
    @(negedge clk);
    total++; if (sram_addr !== 16'd4) begin bad++; $display("FAIL b2b_addr1 got=%h exp=0004", sram_addr); end
    next(); sram_ack = 0;
    next(); set_op(32'd1044, 4'd2, 1, 1, 0);
    @(negedge clk);
    total++; if (Result_WB !== 32'hAAAA0001 || WriteBackEn !== 1'b1 || freeze !== 1'b1) begin
      bad++; $display("FAIL b2b_first result=%h wbe=%b freeze=%b exp aaaa0001/1/1", Result_WB, WriteBackEn, freeze); end
    next(); sram_ack = 1; sram_rdata = 32'hBBBB0002;
    @(negedge clk);
    total++; if (sram_req !== 1'b1 || sram_addr !== 16'd5 || WriteBackEn !== 1'b0) begin
      bad++; $display("FAIL b2b_access2 req=%b addr=%h wbe=%b exp 1/0005/0", sram_req, sram_addr, WriteBackEn); end
    next(); sram_ack = 0;
    next(); set_op(0, 0, 0, 0, 0);
    @(negedge clk);
    total++; if (Result_WB !== 32'hBBBB0002 || Dest_WB !== 4'd2 || WriteBackEn !== 1'b1) begin
      bad++; $display("FAIL b2b_second result=%h dest=%h wbe=%b exp bbbb0002/2/1", Result_WB, Dest_WB, WriteBackEn); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_store();
    test_load();
    test_spurious();
    test_rst_access();
    test_wrap();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
